// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the countdown-timer arbiter.
package timer_arb_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_TW   = 4;

    // LSB of requester idx's duration field inside the flattened req_init bus
    function automatic int init_lsb(input int idx, input int tw);
        return idx * tw;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
    import timer_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW:0] pos;

    // Scan from the far end back toward ptr so the nearest hit wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(NREQ)) pos = pos - (IW + 1)'(NREQ);
            if (req[pos[IW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one countdown timer among NREQ requesters, round-robin.
// Define TIMER_ARB_PRIO_EN to make requester 0 a fixed top-priority requester.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int TW   = DEF_TW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*TW-1:0] req_init,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               timer_load,
    output logic               timer_en,
    output logic [TW-1:0]      timer_init,
    input  logic [TW-1:0]      timer_out
);

    localparam int IW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     init_q, init_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic              timer_load_q, timer_load_d;
    logic              timer_en_q, timer_en_d;
    logic [TW-1:0]     timer_init_q, timer_init_d;

    logic [NREQ-1:0]   rr_req;
    logic              rr_valid, pick_valid;
    logic [IW-1:0]     rr_idx, pick_idx, adv_ptr;
    logic              active, abort;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (rr_req),
        .ptr   (ptr_q),
        .valid (rr_valid),
        .idx   (rr_idx)
    );

`ifdef TIMER_ARB_PRIO_EN
    assign rr_req     = {req[NREQ-1:1], 1'b0};
    assign pick_valid = req[0] | rr_valid;
    assign pick_idx   = req[0] ? '0 : rr_idx;
    // Serving the priority requester leaves the rotation untouched.
    assign adv_ptr    = (idx_q == '0) ? ptr_q :
                        (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
`else
    assign rr_req     = req;
    assign pick_valid = rr_valid;
    assign pick_idx   = rr_idx;
    assign adv_ptr    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
`endif

    assign active = (state_q == LOAD) || (state_q == ARM) || (state_q == RUN);
    assign abort  = active && !req[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        init_d  = init_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                idx_d   = pick_idx;
                init_d  = req_init[init_lsb(int'(pick_idx), TW) +: TW];
                state_d = LOAD;
            end
            LOAD:    state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (timer_out == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
        if (abort || (state_q == RUN && state_d == DONE)) ptr_d = adv_ptr;

        // Outputs are registered copies of what the next state demands.
        gnt_d  = '0;
        done_d = '0;
        if (state_d == LOAD || state_d == ARM || state_d == RUN) gnt_d[idx_d] = 1'b1;
        if (state_d == DONE) done_d[idx_d] = 1'b1;
        busy_d       = (state_d != IDLE);
        timer_load_d = (state_d == LOAD);
        timer_en_d   = (state_d == RUN);
        timer_init_d = init_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ptr_q        <= '0;
            init_q       <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            timer_load_q <= 1'b0;
            timer_en_q   <= 1'b0;
            timer_init_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            init_q       <= init_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            timer_load_q <= timer_load_d;
            timer_en_q   <= timer_en_d;
            timer_init_q <= timer_init_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign timer_load = timer_load_q;
    assign timer_en   = timer_en_q;
    assign timer_init = timer_init_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a behavioural countdown timer stepping every clk.
module tb_timer_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_init;
    logic [3:0]  gnt, done;
    logic        busy, timer_load, timer_en;
    logic [3:0]  timer_init, timer_out;
    logic [3:0]  tmr;

    int n_chk  = 0;
    int n_pass = 0;
    int oh_err = 0;

    always #5 clk = ~clk;

    timer_arbiter #(.NREQ(4), .TW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_init   (req_init),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy),
        .timer_load (timer_load),
        .timer_en   (timer_en),
        .timer_init (timer_init),
        .timer_out  (timer_out)
    );

    // Timer model: load captures init, en decrements each clk, saturates at 0.
    always @(posedge clk) begin
        if (!rst_n)                   tmr <= 4'd0;
        else if (timer_load)          tmr <= timer_init;
        else if (timer_en && tmr != 0) tmr <= tmr - 4'd1;
    end
    assign timer_out = tmr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Hold r, collect n done pulses in the order given by nibbles of exp_seq.
    task automatic run_grants(input logic [3:0] r, input int n, input bit drop,
                              input logic [31:0] exp_seq, input string tag);
        int seen = 0;
        int cyc  = 0;
        logic [3:0] e;
        req = r;
        while (seen < n && cyc < 100) begin
            tick();
            cyc++;
            if (!$onehot0(gnt)) oh_err++;
            if (done != 4'b0) begin
                e = 4'(1 << exp_seq[seen*4 +: 4]);
                chk($sformatf("%s_done%0d", tag, seen), done, e);
                if (drop) req = req & ~done;
                seen++;
            end
        end
        chk({tag, "_count"}, seen, n);
        req = 4'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0;
        req_init = 16'h0;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load", timer_load, 0);
        chk("rst_en", timer_en, 0);
        chk("rst_init", timer_init, 0);
        rst_n = 1'b1;
        tick();

        // single requester 1, duration 3
        req_init = 16'h0030;
        req      = 4'b0010;
        tick();
        chk("t1_gnt", gnt, 4'b0010);
        chk("t1_load", timer_load, 1);
        chk("t1_init", timer_init, 3);
        chk("t1_busy", busy, 1);
        chk("t1_load_en", timer_en, 0);
        tick();
        chk("t1_arm_load", timer_load, 0);
        chk("t1_arm_en", timer_en, 0);
        chk("t1_arm_gnt", gnt, 4'b0010);
        tick();
        chk("t1_run_en", timer_en, 1);
        tick();
        tick();
        tick();
        chk("t1_tmr0", timer_out, 0);
        chk("t1_nodone", done, 0);
        tick();
        chk("t1_done", done, 4'b0010);
        chk("t1_done_gnt", gnt, 0);
        chk("t1_done_en", timer_en, 0);
        req = 4'b0;
        tick();
        chk("t1_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // zero duration, requester 0 (pointer now at 2, wraps to 0)
        req_init = 16'h0;
        req      = 4'b0001;
        tick();
        chk("z_gnt", gnt, 4'b0001);
        tick();
        chk("z_arm_en", timer_en, 0);
        tick();
        chk("z_run_en", timer_en, 1);
        chk("z_run_done", done, 0);
        tick();
        chk("z_done", done, 4'b0001);
        chk("z_done_en", timer_en, 0);
        req = 4'b0;
        tick();
        chk("z_idle", busy, 0);

        // abort requester 2 mid-RUN; pointer must then favour 3 over 1
        req_init = 16'h0500;
        req      = 4'b0100;
        tick();
        chk("ab_gnt", gnt, 4'b0100);
        tick();
        tick();
        tick();
        chk("ab_run_en", timer_en, 1);
        req      = 4'b1010;
        req_init = 16'h1500;
        tick();
        chk("ab_gnt0", gnt, 0);
        chk("ab_en0", timer_en, 0);
        chk("ab_nodone", done, 0);
        chk("ab_busy", busy, 0);
        tick();
        chk("ab_next", gnt, 4'b1000);
        tick();
        tick();
        chk("ab_next_run", timer_en, 1);

        // reset during RUN
        rst_n = 1'b0;
        tick();
        chk("mr_gnt", gnt, 0);
        chk("mr_en", timer_en, 0);
        chk("mr_busy", busy, 0);
        chk("mr_load", timer_load, 0);
        chk("mr_init", timer_init, 0);
        chk("mr_done", done, 0);
        rst_n = 1'b1;
        tick();
        chk("mr_ptr", gnt, 4'b0010);
        req = 4'b0;
        tick();
        chk("mr_abort_idle", busy, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // fairness with all requesting, all durations 1
        req_init = 16'h1111;
`ifdef TIMER_ARB_PRIO_EN
        run_grants(4'b1111, 5, 1'b0, 32'h0000_0000, "rr");
`else
        run_grants(4'b1111, 5, 1'b0, 32'h0000_3210, "rr");
`endif
        chk("rr_onehot", oh_err, 0);

        // move pointer to 2, then contend 0, 2, 3
        run_grants(4'b0010, 1, 1'b1, 32'h0000_0001, "pre");
`ifdef TIMER_ARB_PRIO_EN
        run_grants(4'b1101, 3, 1'b1, 32'h0000_0320, "prio");
`else
        run_grants(4'b1101, 3, 1'b1, 32'h0000_0032, "prio");
`endif
        chk("all_onehot", oh_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
